// File: rtl/rsa_engine_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rsa_engine_arbiter_pkg
// Shared constants for the RSA engine arbiter: default operand/key widths,
// the default per-job timeout and the FSM state encoding.
// ---------------------------------------------------------------------------
package rsa_engine_arbiter_pkg;

    localparam int DEF_RSA_WIDTH = 128;
    localparam int DEF_KEY_WIDTH = 32;
    localparam int DEF_TIMEOUT   = 65535;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_LAUNCH = 3'd1;
    localparam logic [STATE_W-1:0] S_MASK   = 3'd2;
    localparam logic [STATE_W-1:0] S_RUN    = 3'd3;
    localparam logic [STATE_W-1:0] S_FINISH = 3'd4;

endpackage

// File: rtl/rsa_engine_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin selector. The search starts at the index after the last
// accepted winner (index 0 after reset).
//   clk, rst  : clock, asynchronous active-high reset
//   req_i     : one request bit per requester
//   accept_i  : the caller takes grant_o this cycle; advances the pointer
//   grant_o   : combinational one-hot winner (zero when req_i is zero)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        int unsigned idx;
        logic        found;
        idx     = 0;
        found   = 1'b0;
        grant_o = '0;
        ptr_d   = ptr_q;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(ptr_q) + off) % NUM_REQ;
            if (!found && req_i[PW'(idx)]) begin
                found            = 1'b1;
                grant_o[PW'(idx)] = 1'b1;
                ptr_d            = PW'((idx + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rsa_engine_arbiter.sv
// ---------------------------------------------------------------------------
// rsa_engine_arbiter
// Shares one modular-exponentiation engine between NUM_REQ requesters.
// A job: arbitrate (IDLE) -> pulse engine reset (LAUNCH) -> ignore a
// possibly stale ready (MASK) -> wait for ready or timeout (RUN) ->
// pulse done to the owner (FINISH).
//   clk, reset   : clock, asynchronous active-high reset
//   req          : level request per requester, held until done
//   key_sel_in   : key select of requester i in slice i
//   grant        : one-hot owner of the engine
//   done         : one-cycle completion pulse to the owner
//   err          : with done, the job timed out
//   result       : last captured engine result
//   eng_key_sel  : key select driven to the engine
//   eng_reset    : engine reset (also high throughout reset)
//   eng_ready    : engine result valid
//   eng_c        : engine result
// ---------------------------------------------------------------------------
module rsa_engine_arbiter
    import rsa_engine_arbiter_pkg::*;
#(
    parameter int RSA_WIDTH = DEF_RSA_WIDTH,
    parameter int NUM_REQ   = 4,
    parameter int KEY_WIDTH = DEF_KEY_WIDTH,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*KEY_WIDTH-1:0] key_sel_in,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic                         err,
    output logic [RSA_WIDTH-1:0]         result,
    output logic [KEY_WIDTH-1:0]         eng_key_sel,
    output logic                         eng_reset,
    input  logic                         eng_ready,
    input  logic [RSA_WIDTH-1:0]         eng_c
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

    logic [STATE_W-1:0]   state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;
    logic [RSA_WIDTH-1:0] result_q, result_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic                 arb_accept;
    logic [KEY_WIDTH-1:0] key_pick;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk      (clk),
        .rst      (reset),
        .req_i    (req),
        .accept_i (arb_accept),
        .grant_o  (arb_gnt)
    );

    // One-hot AND-OR select of the winner's key slice.
    always_comb begin
        key_pick = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                key_pick = key_pick | key_sel_in[i*KEY_WIDTH +: KEY_WIDTH];
            end
        end
    end

    // Counter value including the current RUN cycle, so the job times out
    // on RUN cycle number TIMEOUT.
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        done_d     = '0;
        err_d      = err_q;
        result_d   = result_q;
        key_d      = key_q;
        cnt_d      = cnt_q;
        arb_accept = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    arb_accept = 1'b1;
                    grant_d    = arb_gnt;
                    key_d      = key_pick;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_MASK;
            end
            S_MASK: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                // Ready takes priority over a coincident timeout.
                if (eng_ready) begin
                    result_d = eng_c;
                    err_d    = 1'b0;
                    done_d   = grant_q;
                    state_d  = S_FINISH;
                end else if (cnt_inc == TMO_C) begin
                    err_d   = 1'b1;
                    done_d  = grant_q;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                grant_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            key_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign err         = err_q;
    assign result      = result_q;
    assign eng_key_sel = key_q;
    // Reset reaches the engine combinationally so it follows reset directly.
    assign eng_reset   = reset | (state_q == S_LAUNCH);

endmodule

// File: tb/tb_rsa_engine_arbiter.sv
module tb_rsa_engine_arbiter;

    localparam int W   = 128;
    localparam int N   = 4;
    localparam int KW  = 32;
    localparam int TMO = 20;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*KW-1:0] key_sel_in = '0;
    logic [N-1:0]    grant, done;
    logic            err;
    logic [W-1:0]    result;
    logic [KW-1:0]   eng_key_sel;
    logic            eng_reset;
    logic            eng_ready = 1'b0;
    logic [W-1:0]    eng_c = '0;

    rsa_engine_arbiter #(
        .RSA_WIDTH (W),
        .NUM_REQ   (N),
        .KEY_WIDTH (KW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .key_sel_in  (key_sel_in),
        .grant       (grant),
        .done        (done),
        .err         (err),
        .result      (result),
        .eng_key_sel (eng_key_sel),
        .eng_reset   (eng_reset),
        .eng_ready   (eng_ready),
        .eng_c       (eng_c)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model (job timeline by cycle offset) -------
    int           cyc = 0;
    bit           busy = 0;
    int           win = 0, start = 0, fin = -1, ptr = 0;
    bit           m_err = 0;
    logic [W-1:0] m_result = '0;
    logic [KW-1:0] m_key = '0;

    // observations for the directed literal checks
    int            n_done = 0, n_engrst = 0, g_cyc = 0, d_cyc = 0;
    logic [N-1:0]  g_val = '0, d_val = '0, prev_grant = '0;
    logic [KW-1:0] g_key = '0;
    bit            d_err = 0;
    logic [W-1:0]  d_res = '0;
    int            order[$];

    always @(negedge clk) begin
        logic [N-1:0] eg, ed;
        bit found;
        cyc++;
        if (reset) begin
            check("rst_grant", W'(grant), '0);
            check("rst_done", W'(done), '0);
            check("rst_err", W'(err), '0);
            check("rst_result", result, '0);
            check("rst_eng_reset", W'(eng_reset), W'(1));
            busy = 0; ptr = 0; fin = -1; m_err = 0; m_result = '0;
            prev_grant = '0;
        end else begin
            eg = busy ? N'(1 << win) : '0;
            ed = (busy && cyc == fin) ? eg : '0;
            check("grant", W'(grant), W'(eg));
            check("done", W'(done), W'(ed));
            check("err", W'(err), W'(ed != '0 && m_err));
            check("eng_reset", W'(eng_reset), W'(busy && cyc == start));
            check("result", result, m_result);
            if (busy) check("eng_key_sel", W'(eng_key_sel), W'(m_key));

            if (grant != '0 && prev_grant == '0) begin
                g_cyc = cyc; g_val = grant; g_key = eng_key_sel;
                for (int k = 0; k < N; k++) if (grant == N'(1 << k)) order.push_back(k);
            end
            if (done != '0) begin
                n_done++; d_cyc = cyc; d_val = done; d_err = err; d_res = result;
            end
            if (eng_reset) n_engrst++;
            prev_grant = grant;

            if (busy) begin
                if (cyc == fin) begin
                    busy = 0;
                end else if (fin < 0 && cyc - start >= 2) begin
                    if (eng_ready) begin
                        fin = cyc + 1; m_err = 0; m_result = eng_c;
                    end else if (cyc - start - 1 == TMO) begin
                        fin = cyc + 1; m_err = 1;
                    end
                end
            end else if (req != '0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && ((req >> ((ptr + k) % N)) & N'(1)) != '0) begin
                        found = 1; win = (ptr + k) % N;
                    end
                end
                busy = 1; start = cyc + 1; fin = -1; ptr = (win + 1) % N;
                m_key = KW'(key_sel_in >> (win * KW));
            end
        end
    end

    // ---------------- engine stub + stimulus ----------------
    int since = 0;
    int ready_at = 1000;
    bit stale = 0;
    bit rand_mode = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (eng_reset) since = 0; else since++;
        if (since == 0) begin
            eng_c = {$urandom, $urandom, $urandom, $urandom};
            if (rand_mode) begin
                stale    = ($urandom_range(0, 3) == 0);
                ready_at = ($urandom_range(0, 4) == 0) ? 1000 : int'($urandom_range(1, 26));
            end
        end
        eng_ready = (stale && since <= 1) || since >= ready_at;
        if (rand_mode && $urandom_range(0, 5) == 0) req = N'($urandom_range(0, 15));
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        d0 = n_done;
        while (n_done == d0 && budget > 0) begin
            step();
            budget--;
        end
        check({name, "_done_seen"}, W'(n_done != d0), W'(1));
    endtask

    initial begin
        logic [W-1:0] prev_c;
        int d0, e0;
        key_sel_in = {$urandom, $urandom, $urandom, 32'd2};
        repeat (3) step();
        reset = 1'b0;

        // single job, ready 10 cycles after eng_reset
        stale = 0; ready_at = 10; e0 = n_engrst;
        req = 4'b0001;
        wait_done(100, "single");
        req = '0;
        check("single_done", W'(d_val), W'(1));
        check("single_err", W'(d_err), '0);
        check("single_key", W'(g_key), W'(2));
        check("single_result", d_res, eng_c);
        check("single_engrst_pulses", W'(n_engrst - e0), W'(1));
        check("single_latency", W'(d_cyc - g_cyc), W'(11));

        // stale ready during LAUNCH/MASK, low for 5 RUN cycles, then high
        stale = 1; ready_at = 7;
        req = 4'b0010;
        wait_done(100, "stale");
        req = '0; stale = 0;
        check("stale_done", W'(d_val), W'(2));
        check("stale_err", W'(d_err), '0);
        check("stale_result", d_res, eng_c);
        check("stale_latency", W'(d_cyc - g_cyc), W'(8));

        // timeout with ready stuck low
        prev_c = eng_c; ready_at = 1000;
        req = 4'b0100;
        wait_done(100, "timeout");
        req = '0;
        check("timeout_done", W'(d_val), W'(4));
        check("timeout_err", W'(d_err), W'(1));
        check("timeout_result", d_res, prev_c);
        check("timeout_latency", W'(d_cyc - g_cyc), W'(22));

        // ready rises on the timeout cycle
        ready_at = 21;
        req = 4'b1000;
        wait_done(100, "simul");
        req = '0;
        check("simul_done", W'(d_val), W'(8));
        check("simul_err", W'(d_err), '0);
        check("simul_result", d_res, eng_c);
        check("simul_latency", W'(d_cyc - g_cyc), W'(22));

        // reset mid-RUN; pointer would otherwise favour requester 3
        ready_at = 1000;
        req = 4'b0010;
        repeat (8) step();
        d0 = n_done;
        reset = 1'b1;
        step();
        step();
        check("midrst_grant", W'(grant), '0);
        reset = 1'b0;
        ready_at = 4;
        req = 4'b1001;
        wait_done(100, "midrst");
        req = '0;
        check("midrst_done_count", W'(n_done - d0), W'(1));
        check("midrst_winner", W'(g_val), W'(1));

        // fairness with all requesters held
        reset = 1'b1;
        step();
        reset = 1'b0;
        order.delete();
        ready_at = 3;
        req = 4'b1111;
        repeat (8) wait_done(100, "fair");
        req = '0;
        check("fair_jobs", W'(order.size()), W'(8));
        for (int i = 0; i < 8 && i < order.size(); i++)
            check("fair_order", W'(order[i]), W'(i % 4));

        // randomized traffic against the model
        rand_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) reset = 1'b1;
            if (i == 2003) reset = 1'b0;
            if (i % 500 == 0) key_sel_in = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        rand_mode = 0;
        req = '0;
        ready_at = 1;
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
